// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
//   state_e          : boot FSM state encoding (CLEAR=0, LOAD=1, RUN=2)
//   NOP_WORD_DEFAULT : ADDI x0,x0,0, used for fill and fault responses
//   addr_ok()        : word-aligned and inside the array
package imem_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Callers zero-extend the byte address to 64 bits so one helper serves any ADDR_W.
  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, no reset on the array.
//   clk   : rising-edge clock
//   we    : write wdata to mem[addr]
//   re    : capture mem[addr] into rdata (rdata holds otherwise)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, one cycle after re
module imem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory with a handshaked, one-cycle-latency fetch port.
// After reset it fills every word with NOP_WORD (CLEAR), accepts program beats (LOAD),
// then serves fetches (RUN). Bad addresses (misaligned or out of range) never alias:
// load beats are dropped and flagged on ld_err, fetches return NOP_WORD with if_fault.
//   clk, rst                  : clock, asynchronous active-high reset
//   ld_valid/ready/addr/data  : program-load beat handshake (LOAD only)
//   ld_last                   : final beat, moves to RUN
//   ld_err                    : sticky dropped-beat flag, cleared by reload
//   reload                    : RUN -> LOAD keeping memory contents
//   if_req/ready/addr         : fetch request handshake (RUN only)
//   if_valid/instr/fault      : fetch response, one-cycle pulse
//   state_o                   : current FSM state
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_err,
  input  logic              reload,
  input  logic              if_req,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_fault,
  output logic [1:0]        state_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               vld_q, vld_d;
  logic               flt_q, flt_d;
  logic [DATA_W-1:0]  hold_q;

  logic               ld_ok, if_ok;
  logic [IDX_W-1:0]   ld_idx, if_idx;
  logic               ram_we, ram_re;
  logic [IDX_W-1:0]   ram_addr;
  logic [DATA_W-1:0]  ram_wdata, ram_rdata;
  logic [DATA_W-1:0]  resp;

  assign ld_ok  = addr_ok(64'(ld_addr), DEPTH);
  assign if_ok  = addr_ok(64'(if_addr), DEPTH);
  assign ld_idx = ld_addr[IDX_W+1:2];
  assign if_idx = if_addr[IDX_W+1:2];

  // Exactly one source owns the RAM port in each state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    vld_d     = 1'b0;
    flt_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = NOP_WORD;
    unique case (state_q)
      StClear: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = StLoad;
      end
      StLoad: begin
        if (ld_valid) begin
          if (ld_ok) begin
            ram_we    = 1'b1;
            ram_addr  = ld_idx;
            ram_wdata = ld_data;
          end else begin
            err_d = 1'b1;
          end
          if (ld_last) state_d = StRun;
        end
      end
      StRun: begin
        if (if_req) begin
          vld_d = 1'b1;
          flt_d = !if_ok;
          if (if_ok) begin
            ram_re   = 1'b1;
            ram_addr = if_idx;
          end
        end
        // A fetch accepted alongside reload still gets its response next cycle.
        if (reload) begin
          state_d = StLoad;
          err_d   = 1'b0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
      hold_q  <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      flt_q   <= flt_d;
      if (vld_q) hold_q <= resp;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Faulted fetches never read the RAM, so the response is substituted here.
  assign resp     = flt_q ? NOP_WORD : ram_rdata;
  assign if_instr = vld_q ? resp : hold_q;
  assign if_valid = vld_q;
  assign if_fault = vld_q & flt_q;
  assign ld_ready = (state_q == StLoad);
  assign if_ready = (state_q == StRun);
  assign ld_err   = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable at default parameters (DEPTH=1024).
module tb_imem_loadable;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_err;
  logic        reload = 1'b0;
  logic        if_req = 1'b0;
  logic        if_ready;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_fault;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  imem_loadable dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_err   (ld_err),
    .reload   (reload),
    .if_req   (if_req),
    .if_ready (if_ready),
    .if_addr  (if_addr),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_fault (if_fault),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CLEAR must last exactly DEPTH edges after reset release.
  task automatic do_clear(input string tag);
    for (int i = 1; i < DEPTH; i++) step();
    chk({tag, "_still_clear"}, 32'(state_o), 32'd0);
    step();
    chk({tag, "_load"}, 32'(state_o), 32'd1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    step();
    if_req  = 1'b0;
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0030_0093;
    prog[1] = 32'h0050_0113;
    prog[2] = 32'h0070_0193;
    prog[3] = 32'h0020_81B3;

    // Reset values
    rst = 1'b1;
    step();
    chk("rst_state",    32'(state_o),  32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_err",   32'(ld_err),   32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_fault", 32'(if_fault), 32'd0);
    chk("rst_if_instr", if_instr,      NOP);
    rst = 1'b0;
    do_clear("clr0");
    chk("load_ld_ready", 32'(ld_ready), 32'd1);
    chk("load_if_ready", 32'(if_ready), 32'd0);

    // Fetch requests are ignored outside RUN
    fetch(32'h0);
    chk("load_fetch_ignored", 32'(if_valid), 32'd0);

    // Single-beat program, then an unloaded word reads as NOP
    beat(32'h0, prog[0], 1'b1);
    chk("run_state",    32'(state_o),  32'd2);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    chk("run_if_ready", 32'(if_ready), 32'd1);
    fetch(32'h4);
    chk("f4_valid", 32'(if_valid), 32'd1);
    chk("f4_instr", if_instr,      NOP);
    chk("f4_fault", 32'(if_fault), 32'd0);
    step();
    chk("f4_pulse_end", 32'(if_valid), 32'd0);
    fetch(32'h0);
    chk("f0_instr", if_instr, prog[0]);

    // Load beats in RUN are not accepted
    beat(32'h0, 32'hFFFF_FFFF, 1'b1);
    chk("run_ld_ignored", 32'(state_o), 32'd2);

    // Reload to LOAD; reload in LOAD is ignored
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload_state", 32'(state_o), 32'd1);
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload_in_load", 32'(state_o), 32'd1);

    // Four-word program with two dropped beats interleaved
    beat(32'h0, prog[0], 1'b0);
    beat(32'h4, prog[1], 1'b0);
    beat(32'h1000, 32'hBAD0_0000, 1'b0);
    chk("oor_ld_err", 32'(ld_err),  32'd1);
    chk("oor_state",  32'(state_o), 32'd1);
    beat(32'h8, prog[2], 1'b0);
    beat(32'hA, 32'hDEAD_BEEF, 1'b0);
    beat(32'hC, prog[3], 1'b1);
    chk("prog_run",    32'(state_o), 32'd2);
    chk("ld_err_sticky", 32'(ld_err), 32'd1);

    // Back-to-back fetches, one response per cycle
    if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'(i * 4);
      step();
      chk($sformatf("b2b%0d_valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("b2b%0d_instr", i), if_instr,      prog[i]);
      chk($sformatf("b2b%0d_fault", i), 32'(if_fault), 32'd0);
    end
    if_req = 1'b0;
    step();
    chk("b2b_end_valid", 32'(if_valid), 32'd0);
    chk("b2b_hold_instr", if_instr,     prog[3]);

    // Bad and boundary fetch addresses
    fetch(32'h2);
    chk("mis_valid", 32'(if_valid), 32'd1);
    chk("mis_fault", 32'(if_fault), 32'd1);
    chk("mis_instr", if_instr,      NOP);
    step();
    chk("mis_fault_clear", 32'(if_fault), 32'd0);
    fetch(32'h1000);
    chk("oor_fault", 32'(if_fault), 32'd1);
    chk("oor_instr", if_instr,      NOP);
    fetch(32'h10);
    chk("unloaded_fault", 32'(if_fault), 32'd0);
    chk("unloaded_instr", if_instr,      NOP);
    fetch(32'hFFC);
    chk("top_valid", 32'(if_valid), 32'd1);
    chk("top_fault", 32'(if_fault), 32'd0);
    chk("top_instr", if_instr,      NOP);

    // Reload and fetch in the same cycle
    reload  = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h4;
    step();
    reload = 1'b0;
    if_req = 1'b0;
    chk("rf_valid",    32'(if_valid), 32'd1);
    chk("rf_instr",    if_instr,      prog[1]);
    chk("rf_if_ready", 32'(if_ready), 32'd0);
    chk("rf_state",    32'(state_o),  32'd1);
    chk("rf_ld_err",   32'(ld_err),   32'd0);

    // Memory kept across reload
    beat(32'h10, 32'h1111_1111, 1'b1);
    fetch(32'h0);
    chk("kept_w0", if_instr, prog[0]);
    fetch(32'h10);
    chk("new_w4", if_instr, 32'h1111_1111);

    // Reset mid-fetch discards the response immediately
    fetch(32'h4);
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mf_rst_valid",    32'(if_valid), 32'd0);
    chk("mf_rst_instr",    if_instr,      NOP);
    chk("mf_rst_state",    32'(state_o),  32'd0);
    chk("mf_rst_if_ready", 32'(if_ready), 32'd0);
    step();
    rst = 1'b0;
    do_clear("clr1");

    // Reset mid-LOAD clears ld_err and restarts CLEAR
    beat(32'h1000, 32'h0, 1'b0);
    chk("ml_err_set", 32'(ld_err), 32'd1);
    beat(32'h4, 32'h2222_2222, 1'b0);
    rst = 1'b1;
    #1;
    chk("ml_rst_err",   32'(ld_err),   32'd0);
    chk("ml_rst_ready", 32'(ld_ready), 32'd0);
    chk("ml_rst_state", 32'(state_o),  32'd0);
    step();
    rst = 1'b0;
    do_clear("clr2");
    beat(32'h0, 32'h3333_3333, 1'b1);
    fetch(32'h4);
    chk("refilled_w1", if_instr, NOP);
    fetch(32'h0);
    chk("reload_w0", if_instr, 32'h3333_3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory with a program-load port and a registered, handshaked fetch port. After reset, a boot FSM fills every word with NOP, then accepts a program as word writes from a loader, then serves fetches from the core's PC. It replaces the fixed, initial-block-programmed instruction ROM: programs load at run time, reads are synchronous (one-cycle latency), and bad addresses are flagged instead of aliasing.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 1024, number of words; power of two
- ADDR_W, 32, byte-address width on both ports
- NOP_WORD, 32'h00000013, fill value and fault-response value (ADDI x0,x0,0)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  load beat present
- ld_ready  out  1  load beat accepted this cycle when both high
- ld_addr  in  ADDR_W  byte address of load word
- ld_data  in  DATA_W  load word
- ld_last  in  1  final beat of program
- ld_err  out  1  sticky: a load beat was dropped (misaligned/out of range)
- reload  in  1  RUN only: return to LOAD without clearing
- if_req  in  1  fetch request
- if_ready  out  1  fetch accepted when if_req && if_ready
- if_addr  in  ADDR_W  fetch byte address (PC)
- if_valid  out  1  one-cycle pulse: response valid
- if_instr  out  DATA_W  fetched word
- if_fault  out  1  qualifies if_valid: misaligned or out-of-range fetch
- state_o  out  2  current FSM state (CLEAR=0, LOAD=1, RUN=2)

## Operation
- Word index = addr >> 2. Address is bad if addr[1:0] != 0 or index >= DEPTH.
- FSM:
  - CLEAR: counter 0..DEPTH-1 writes NOP_WORD, one word per cycle. Advances to LOAD after writing index DEPTH-1. ld_ready=0, if_ready=0.
  - LOAD: ld_ready=1, if_ready=0.
    - An accepted beat with a good address writes mem[index]=ld_data on that edge.
    - An accepted beat with a bad address is dropped and sets ld_err.
    - An accepted beat with ld_last=1 moves the FSM to RUN; that beat is still written if its address is good.
  - RUN: if_ready=1, ld_ready=0.
    - reload=1 moves the FSM to LOAD next cycle and clears ld_err; memory is kept.
    - reload is ignored in CLEAR and LOAD.
- Fetch, RUN only:
  - An accepted request yields if_valid=1 on the next cycle for exactly one cycle.
  - Good address: if_instr=mem[index], if_fault=0.
  - Bad address: if_instr=NOP_WORD, if_fault=1; memory is not read.
  - Back-to-back requests are accepted every cycle, giving a full-throughput response stream.
- Reload and fetch in the same cycle: the fetch is accepted and its response is delivered the next cycle, even though the state is then LOAD.
- Outputs when if_valid=0: if_instr holds its last value and if_fault=0.
- The memory array is not reset. Contents are defined only by CLEAR and LOAD.

## Timing
- Reset values, asserted asynchronously:
  - state_o=CLEAR, clear counter=0
  - ld_ready=0, ld_err=0
  - if_ready=0, if_valid=0, if_fault=0, if_instr=NOP_WORD
- Reset mid-CLEAR, mid-LOAD or mid-fetch restarts CLEAR from index 0. An in-flight fetch response is discarded (if_valid=0).
- CLEAR takes exactly DEPTH cycles. state_o=LOAD on cycle DEPTH after reset release.
- ld_ready and if_ready are pure decodes of state: no combinational path from ld_valid or if_req.
- Fetch latency: 1 cycle from acceptance edge to if_valid.
- A load write followed by a fetch of the same word is always coherent, because RUN is entered only after the ld_last edge.

## Structure
- Package imem_pkg:
  - state enum (CLEAR, LOAD, RUN)
  - NOP_WORD default
  - function addr_ok(addr, DEPTH) returning the good-address flag
- One natural sub-module, imem_ram: single-port synchronous RAM, DEPTH×DATA_W, with write enable and registered read. The top mux chooses which source drives the RAM port (clear counter, loader or fetch); only one is active per state.

## Test plan
- Reset, then count cycles → state_o=LOAD exactly DEPTH cycles after release. Load nothing but a single beat {addr 0x0, 32'h00300093, last} → in RUN, a fetch of 0x4 returns 32'h00000013 with if_fault=0.
- Load words 32'h00300093, 32'h00500113, 32'h00700193, 32'h002081B3 at 0x0..0xC (last on 0xC), then fetch 0x0,0x4,0x8,0xC on consecutive cycles → four consecutive if_valid pulses with those words in order, each 1 cycle after its request.
- Fetch 0x2 → if_fault=1, if_instr=32'h00000013. Fetch 0x1000 at DEPTH=1024 → if_fault=1.
- In LOAD, send a beat to 0x1000 → ld_err=1 and no write occurs. Assert reload in RUN → ld_err=0 and state_o=LOAD, with previously loaded words intact.
- Assert reload and accept a fetch of 0x4 in the same cycle → the next cycle has if_valid=1 with the word at 0x4, and if_ready=0.
- Assert rst mid-LOAD and mid-fetch → all outputs take their reset values immediately, the pending if_valid is suppressed, and CLEAR restarts from index 0.
